// File: rtl/tqv_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tqv_uart_tx_fifo
// Brief   : FIFO-buffered UART transmitter with runtime divider and framing.
// Rev     : 1.0 - initial release
// ============================================================================
module tqv_uart_tx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 12,
    parameter int DIV_RESET  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  addr_in,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic        interrupt
);

    localparam int         c_AW         = $clog2(FIFO_DEPTH);
    localparam int         c_LW         = c_AW + 1;
    localparam logic [1:0] c_REG_DATA   = 2'd0;
    localparam logic [1:0] c_REG_STATUS = 2'd1;
    localparam logic [1:0] c_REG_DIV    = 2'd2;
    localparam logic [1:0] c_REG_CTRL   = 2'd3;
    localparam logic [c_LW-1:0] c_FULL  = FIFO_DEPTH[c_LW-1:0];

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_t;

    // Register file and FIFO storage
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_LW-1:0]      r_level;
    logic                 r_ovf;
    logic [DIV_WIDTH-1:0] r_div;
    logic [3:0]           r_ctrl;

    // Transmit engine state; frame-local copies keep the frame immune to
    // register writes made while it is on the wire.
    tx_state_t            r_state;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [7:0]           r_shift;
    logic [2:0]           r_bit_idx;
    logic                 r_stop_second;
    logic [DIV_WIDTH-1:0] r_div_lat;
    logic                 r_par_en_lat;
    logic                 r_par_bit;
    logic                 r_two_stop_lat;
    logic                 r_txd;
    logic                 r_busy;
    logic                 r_irq;

    tx_state_t            w_state_next;
    logic [DIV_WIDTH-1:0] w_cnt_next;
    logic [7:0]           w_shift_next;
    logic [2:0]           w_bit_idx_next;
    logic                 w_stop_second_next;
    logic [DIV_WIDTH-1:0] w_div_lat_next;
    logic                 w_par_en_next;
    logic                 w_par_bit_next;
    logic                 w_two_stop_next;
    logic                 w_txd_next;
    logic                 w_pop;
    logic                 w_load;

    logic                 w_wr_en;
    logic [1:0]           w_sel;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_bit_end;
    logic                 w_busy_now;
    logic [7:0]           w_fifo_rdata;
    logic [c_LW-1:0]      w_level_next;
    logic [3:0]           w_ctrl_next;
    logic                 w_unused;

    assign w_wr_en      = (data_write_n != 2'b11);
    assign w_sel        = addr_in[3:2];
    assign w_push_req   = w_wr_en && (w_sel == c_REG_DATA);
    assign w_empty      = (r_level == '0);
    assign w_full       = (r_level == c_FULL);
    assign w_push       = w_push_req && (!w_full || w_pop);
    assign w_fifo_rdata = r_mem[r_rd_ptr];
    assign w_level_next = r_level + c_LW'(w_push) - c_LW'(w_pop);
    assign w_ctrl_next  = (w_wr_en && (w_sel == c_REG_CTRL)) ? data_in[3:0] : r_ctrl;
    assign w_bit_end    = (r_cnt == '0);
    assign w_busy_now   = !w_empty || (r_state != S_IDLE);
    assign w_unused     = &{1'b0, data_read_n, addr_in[1:0], data_in, 1'b0};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
            r_div    <= DIV_WIDTH'(DIV_RESET);
            r_ctrl   <= 4'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_level <= w_level_next;
            if (w_push_req && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_wr_en && (w_sel == c_REG_STATUS) && data_in[3]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr_en && (w_sel == c_REG_DIV)) begin
                r_div <= data_in[DIV_WIDTH-1:0];
            end
            r_ctrl <= w_ctrl_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_shift        <= 8'd0;
            r_bit_idx      <= 3'd0;
            r_stop_second  <= 1'b0;
            r_div_lat      <= '0;
            r_par_en_lat   <= 1'b0;
            r_par_bit      <= 1'b0;
            r_two_stop_lat <= 1'b0;
            r_txd          <= 1'b1;
            r_busy         <= 1'b0;
            r_irq          <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_shift        <= w_shift_next;
            r_bit_idx      <= w_bit_idx_next;
            r_stop_second  <= w_stop_second_next;
            r_div_lat      <= w_div_lat_next;
            r_par_en_lat   <= w_par_en_next;
            r_par_bit      <= w_par_bit_next;
            r_two_stop_lat <= w_two_stop_next;
            r_txd          <= w_txd_next;
            r_busy         <= (w_level_next != '0) || (w_state_next != S_IDLE);
            r_irq          <= w_ctrl_next[3] && (w_level_next == '0) && (w_state_next == S_IDLE);
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_shift_next       = r_shift;
        w_bit_idx_next     = r_bit_idx;
        w_stop_second_next = r_stop_second;
        w_div_lat_next     = r_div_lat;
        w_par_en_next      = r_par_en_lat;
        w_par_bit_next     = r_par_bit;
        w_two_stop_next    = r_two_stop_lat;
        w_load             = 1'b0;
        w_pop              = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_load = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next   = S_DATA;
                    w_cnt_next     = r_div_lat;
                    w_bit_idx_next = 3'd0;
                end else begin
                    w_cnt_next = r_cnt - DIV_WIDTH'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_next   = r_div_lat;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_next       = r_par_en_lat ? S_PARITY : S_STOP;
                        w_stop_second_next = 1'b0;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt - DIV_WIDTH'(1);
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_next         = r_div_lat;
                    w_state_next       = S_STOP;
                    w_stop_second_next = 1'b0;
                end else begin
                    w_cnt_next = r_cnt - DIV_WIDTH'(1);
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_two_stop_lat && !r_stop_second) begin
                        w_stop_second_next = 1'b1;
                        w_cnt_next         = r_div_lat;
                    end else if (!w_empty) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - DIV_WIDTH'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Frame start: pop a byte and snapshot the live configuration
        if (w_load) begin
            w_pop           = 1'b1;
            w_state_next    = S_START;
            w_shift_next    = w_fifo_rdata;
            w_div_lat_next  = r_div;
            w_cnt_next      = r_div;
            w_par_en_next   = r_ctrl[0];
            w_par_bit_next  = r_ctrl[1] ? ~^w_fifo_rdata : ^w_fifo_rdata;
            w_two_stop_next = r_ctrl[2];
        end

        case (w_state_next)
            S_IDLE:   w_txd_next = 1'b1;
            S_START:  w_txd_next = 1'b0;
            S_DATA:   w_txd_next = w_shift_next[0];
            S_PARITY: w_txd_next = w_par_bit_next;
            S_STOP:   w_txd_next = 1'b1;
            default:  w_txd_next = 1'b1;
        endcase
    end

    always_comb begin
        data_out = 32'd0;
        case (w_sel)
            c_REG_DATA:   data_out[c_LW-1:0]      = r_level;
            c_REG_STATUS: data_out[3:0]           = {r_ovf, w_empty, w_full, w_busy_now};
            c_REG_DIV:    data_out[DIV_WIDTH-1:0] = r_div;
            c_REG_CTRL:   data_out[3:0]           = r_ctrl;
            default:      data_out                = 32'd0;
        endcase
    end

    assign data_ready = 1'b1;
    assign uart_txd   = r_txd;
    assign tx_busy    = r_busy;
    assign interrupt  = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_tqv_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_tqv_uart_tx_fifo
// Brief   : Self-checking bench for tqv_uart_tx_fifo (vectors, directed, random).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_tqv_uart_tx_fifo;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic [3:0]  addr_in;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        uart_txd;
    logic        tx_busy;
    logic        interrupt;

    tqv_uart_tx_fifo #(
        .FIFO_DEPTH (DEPTH),
        .DIV_WIDTH  (12),
        .DIV_RESET  (15)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_read_n  (data_read_n),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .uart_txd     (uart_txd),
        .tx_busy      (tx_busy),
        .interrupt    (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO as a queue, the frame as an explicit bit list
    // indexed by elapsed time divided by the bit period.
    byte unsigned m_q[$];
    bit           m_active;
    int           m_start;
    int           m_len;
    int           m_per;
    bit           m_bits[12];
    logic [11:0]  m_div;
    logic [3:0]   m_ctrl;
    bit           m_ovf;
    int           m_cyc;
    bit           m_txd, m_busy, m_irq;

    int cyc_count = 0;
    int fall_t[$];
    logic prev_txd = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc_count, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_q.delete();
        m_active = 0;
        m_div    = 12'd15;
        m_ctrl   = 4'd0;
        m_ovf    = 0;
        m_txd    = 1;
        m_busy   = 0;
        m_irq    = 0;
    endfunction

    function automatic void m_start_frame();
        byte unsigned b;
        b = m_q.pop_front();
        m_per = int'(m_div) + 1;
        m_bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) m_bits[1+k] = b[k];
        m_len = 9;
        if (m_ctrl[0]) begin
            m_bits[m_len] = m_ctrl[1] ? ~^b : ^b;
            m_len++;
        end
        m_bits[m_len] = 1'b1;
        m_len++;
        if (m_ctrl[2]) begin
            m_bits[m_len] = 1'b1;
            m_len++;
        end
        m_active = 1;
        m_start  = m_cyc;
    endfunction

    function automatic void m_step(input logic [3:0] a, input logic [31:0] d, input bit wr);
        m_cyc++;
        if (m_active && (m_cyc - m_start) == m_len * m_per) m_active = 0;
        if (!m_active && m_q.size() > 0) m_start_frame();
        if (wr) begin
            case (a[3:2])
                2'd0: if (m_q.size() < DEPTH) m_q.push_back(d[7:0]); else m_ovf = 1;
                2'd1: if (d[3]) m_ovf = 0;
                2'd2: m_div = d[11:0];
                default: m_ctrl = d[3:0];
            endcase
        end
        m_txd  = m_active ? m_bits[(m_cyc - m_start) / m_per] : 1'b1;
        m_busy = m_active || (m_q.size() > 0);
        m_irq  = m_ctrl[3] && !m_busy;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a[3:2])
            2'd0:    return 32'(m_q.size());
            2'd1:    return {28'd0, m_ovf, m_q.size() == 0, m_q.size() == DEPTH, m_busy};
            2'd2:    return {20'd0, m_div};
            default: return {28'd0, m_ctrl};
        endcase
    endfunction

    // One bus cycle, entered and left at a falling edge.
    task automatic cycle(input logic [3:0] a, input logic [31:0] d, input bit wr, input bit rd,
                         output logic [31:0] rdata);
        addr_in      = a;
        data_in      = d;
        data_write_n = wr ? 2'b00 : 2'b11;
        data_read_n  = rd ? 2'b10 : 2'b11;
        #1;
        rdata = data_out;
        if (rd) chk("rdata_model", data_out, m_read(a));
        @(negedge clk);
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        m_step(a, d, wr);
        cyc_count++;
        chk("txd_model", uart_txd, m_txd);
        chk("busy_model", tx_busy, m_busy);
        chk("irq_model", interrupt, m_irq);
        if (prev_txd === 1'b1 && uart_txd === 1'b0) fall_t.push_back(cyc_count);
        prev_txd = uart_txd;
    endtask

    task automatic idle(input int n);
        logic [31:0] rd;
        for (int i = 0; i < n; i++) cycle(4'h0, 32'h0, 1'b0, 1'b0, rd);
    endtask

    task automatic run_until_idle(input int budget, output int idx);
        logic [31:0] rd;
        idx = -1;
        for (int n = 0; n < budget; n++) begin
            cycle(4'h0, 32'h0, 1'b0, 1'b0, rd);
            if (tx_busy === 1'b0) begin
                idx = cyc_count;
                break;
            end
        end
        if (idx < 0) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", budget);
        end
    endtask

    // Sends one byte from an idle, empty state and compares the whole waveform.
    task automatic check_frame(input logic [7:0] b, input int per, input bit pe, input bit odd,
                               input bit two, input string name);
        bit bits[12];
        int len;
        int errs;
        logic exp;
        logic [31:0] rd;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[1+k] = b[k];
        len = 9;
        if (pe) begin
            bits[len] = odd ? ~^b : ^b;
            len++;
        end
        bits[len] = 1'b1;
        len++;
        if (two) begin
            bits[len] = 1'b1;
            len++;
        end
        errs = 0;
        cycle(4'h0, {24'h0, b}, 1'b1, 1'b0, rd);
        chk({name, "_busy_rise"}, tx_busy, 1);
        if (uart_txd !== 1'b1) errs++;
        for (int j = 1; j <= len * per + 1; j++) begin
            cycle(4'h0, 32'h0, 1'b0, 1'b0, rd);
            exp = (j <= len * per) ? bits[(j - 1) / per] : 1'b1;
            if (uart_txd !== exp) errs++;
        end
        chk({name, "_wave_errs"}, errs, 0);
        chk({name, "_busy_end"}, tx_busy, 0);
    endtask

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
        bit          wr;
        bit          rd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int idx;
        int c1;
        int target;
        int r;
        logic [3:0] a;
        logic [31:0] d;

        tbl[0]  = '{4'h0, 32'h0,         1'b0, 1'b1, 32'h0};
        tbl[1]  = '{4'h4, 32'h0,         1'b0, 1'b1, 32'h4};
        tbl[2]  = '{4'h8, 32'h0,         1'b0, 1'b1, 32'hF};
        tbl[3]  = '{4'hC, 32'h0,         1'b0, 1'b1, 32'h0};
        tbl[4]  = '{4'h8, 32'h0000_0ABC, 1'b1, 1'b0, 32'h0};
        tbl[5]  = '{4'h8, 32'h0,         1'b0, 1'b1, 32'hABC};
        tbl[6]  = '{4'h8, 32'hFFFF_F123, 1'b1, 1'b0, 32'h0};
        tbl[7]  = '{4'h8, 32'h0,         1'b0, 1'b1, 32'h123};
        tbl[8]  = '{4'hC, 32'hFFFF_FFF6, 1'b1, 1'b0, 32'h0};
        tbl[9]  = '{4'hC, 32'h0,         1'b0, 1'b1, 32'h6};
        tbl[10] = '{4'hC, 32'h0,         1'b1, 1'b0, 32'h0};
        tbl[11] = '{4'h8, 32'hF,         1'b1, 1'b0, 32'h0};
        tbl[12] = '{4'h4, 32'h8,         1'b1, 1'b0, 32'h0};
        tbl[13] = '{4'h4, 32'h0,         1'b0, 1'b1, 32'h4};

        rst_n        = 1'b0;
        addr_in      = 4'h0;
        data_in      = 32'h0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        m_cyc        = 0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("reset_txd", uart_txd, 1);
        chk("reset_busy", tx_busy, 0);
        chk("reset_irq", interrupt, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].a, tbl[i].d, tbl[i].wr, tbl[i].rd, rd);
            chk("ready", data_ready, 1);
            if (tbl[i].rd) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
        end

        check_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, "default_frame");

        cycle(4'h8, 32'd3, 1'b1, 1'b0, rd);
        cycle(4'hC, 32'h5, 1'b1, 1'b0, rd);
        check_frame(8'h07, 4, 1'b1, 1'b0, 1'b1, "even_par");
        cycle(4'hC, 32'h7, 1'b1, 1'b0, rd);
        check_frame(8'h07, 4, 1'b1, 1'b1, 1'b1, "odd_par");

        // Divider change during frame 1 only affects frame 2
        cycle(4'hC, 32'h0, 1'b1, 1'b0, rd);
        fall_t.delete();
        cycle(4'h0, 32'hFF, 1'b1, 1'b0, rd);
        cycle(4'h0, 32'hFF, 1'b1, 1'b0, rd);
        idle(5);
        cycle(4'h8, 32'd7, 1'b1, 1'b0, rd);
        run_until_idle(400, idx);
        chk("middiv_frames", fall_t.size(), 2);
        if (fall_t.size() == 2) begin
            chk("middiv_frame1_len", fall_t[1] - fall_t[0], 40);
            chk("middiv_frame2_len", idx - fall_t[1], 80);
        end

        // Overflow, sticky clear, then a push aligned with a full-FIFO pop
        cycle(4'h8, 32'd100, 1'b1, 1'b0, rd);
        fall_t.delete();
        c1 = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(4'h0, 32'hFF, 1'b1, 1'b0, rd);
            if (i == 0) c1 = cyc_count;
        end
        cycle(4'h4, 32'h0, 1'b0, 1'b1, rd);
        chk("ovf_status", rd, 32'hB);
        cycle(4'h0, 32'h0, 1'b0, 1'b1, rd);
        chk("ovf_level", rd, 32'd8);
        cycle(4'h4, 32'h8, 1'b1, 1'b0, rd);
        cycle(4'h4, 32'h0, 1'b0, 1'b1, rd);
        chk("ovf_clear", rd, 32'h3);
        target = c1 + 1 + 10 * 101;
        while (cyc_count + 1 < target) idle(1);
        cycle(4'h0, 32'hFF, 1'b1, 1'b0, rd);
        cycle(4'h4, 32'h0, 1'b0, 1'b1, rd);
        chk("simul_status", rd, 32'h3);
        cycle(4'h0, 32'h0, 1'b0, 1'b1, rd);
        chk("simul_level", rd, 32'd8);
        run_until_idle(12000, idx);
        chk("ovf_frames", fall_t.size(), 10);
        if (fall_t.size() > 0) chk("ovf_no_gap_span", idx - fall_t[0], 10 * 10 * 101);

        // Asynchronous reset in the middle of a frame
        cycle(4'h8, 32'd3, 1'b1, 1'b0, rd);
        cycle(4'h0, 32'h5A, 1'b1, 1'b0, rd);
        cycle(4'h0, 32'h33, 1'b1, 1'b0, rd);
        idle(7);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_txd", uart_txd, 1);
        chk("midrst_busy", tx_busy, 0);
        chk("midrst_irq", interrupt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        prev_txd = uart_txd;
        cycle(4'h0, 32'h0, 1'b0, 1'b1, rd);
        chk("midrst_level", rd, 32'd0);
        cycle(4'h4, 32'h0, 1'b0, 1'b1, rd);
        chk("midrst_status", rd, 32'h4);
        cycle(4'h8, 32'h0, 1'b0, 1'b1, rd);
        chk("midrst_div", rd, 32'd15);

        // Drain interrupt
        cycle(4'hC, 32'h8, 1'b1, 1'b0, rd);
        chk("irq_on", interrupt, 1);
        cycle(4'h0, 32'h3C, 1'b1, 1'b0, rd);
        chk("irq_drop", interrupt, 0);
        run_until_idle(400, idx);
        chk("irq_back", interrupt, 1);

        // Randomised traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            a = 4'($urandom_range(0, 3) << 2);
            d = $urandom();
            if (r < 8) begin
                cycle(4'h0, d, 1'b1, 1'b0, rd);
            end else if (r < 10) begin
                cycle(4'h8, 32'($urandom_range(0, 4)), 1'b1, 1'b0, rd);
            end else if (r < 12) begin
                cycle(4'hC, d, 1'b1, 1'b0, rd);
            end else if (r < 13) begin
                cycle(4'h4, 32'h8, 1'b1, 1'b0, rd);
            end else begin
                cycle(a, d, 1'b0, r[0], rd);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
